// File: rtl/polylut_pipe_ctrl.sv
// Valid/ready flow controller for the registered PolyLUT-Add pipeline: per-stage valid/tag tracking,
// bubble-collapsing load enables and backpressure. Optional counters under POLYLUT_PIPE_PERF_CNT_EN.
module polylut_pipe_ctrl #(
   parameter  int NUM_STAGES = 6,
   parameter  int TAG_W      = 16,
   parameter  int CNT_W      = 32,
   localparam int OCC_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  flush,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [TAG_W-1:0]      out_tag,
   output logic [OCC_W-1:0]      occupancy,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      done_count
);

   logic [NUM_STAGES-1:0] v;
   logic [TAG_W-1:0]      tag [NUM_STAGES];
   logic [TAG_W-1:0]      next_tag;
   logic [NUM_STAGES-1:0] en;
   logic                  accept;

   // A stage may load when it, or any stage downstream of it, is empty or the output drains.
   // Walking from the output end with a running OR avoids a self-referencing enable vector.
   always_comb begin
      logic run;
      // NOTE: every always_comb output gets a default before any conditional path, so no latch is inferred.
      run = out_ready;
      en  = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         run   = run | ~v[i];
         en[i] = run;
      end
   end

   assign stage_en  = en;
   assign in_ready  = en[0] & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = v[NUM_STAGES-1];
   assign out_tag   = tag[NUM_STAGES-1];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         occupancy = occupancy + OCC_W'(v[i]);
   end

   // NOTE: the tag array is reset too, because out_tag is a visible output that must read 0 after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v        <= '0;
         next_tag <= '0;
         for (int i = 0; i < NUM_STAGES; i++)
            tag[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage shift from the pre-edge value of its predecessor.
         if (accept)
            next_tag <= next_tag + 1'b1;
         if (en[0]) begin
            v[0]   <= in_valid;
            tag[0] <= next_tag;
         end
         for (int i = 1; i < NUM_STAGES; i++) begin
            if (en[i]) begin
               v[i]   <= v[i-1];
               tag[i] <= tag[i-1];
            end
         end
         // Flush wins over any load in the same cycle; tags left behind are harmless.
         if (flush)
            v <= '0;
      end
   end

`ifdef POLYLUT_PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         done_q  <= '0;
      end else begin
         if (out_valid && !out_ready && !flush && !(&stall_q))
            stall_q <= stall_q + 1'b1;
         if (out_valid && out_ready && !flush && !(&done_q))
            done_q <= done_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign done_count   = done_q;
`else
   assign stall_cycles = '0;
   assign done_count   = '0;
`endif

endmodule

// File: tb/tb_polylut_pipe_ctrl.sv
// Self-checking bench for polylut_pipe_ctrl: directed scenarios plus randomized traffic against a
// queue-of-positions reference model of the pipeline.
module tb_polylut_pipe_ctrl;

   localparam int N     = 6;
   localparam int TAG_W = 16;
   localparam int CNT_W = 32;
   localparam int OCC_W = $clog2(N + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             flush;
   logic [N-1:0]     stage_en;
   logic [TAG_W-1:0] out_tag;
   logic [OCC_W-1:0] occupancy;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] done_count;

   int passed = 0;
   int total  = 0;

   polylut_pipe_ctrl #(.NUM_STAGES(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .stage_en(stage_en), .out_tag(out_tag), .occupancy(occupancy),
      .stall_cycles(stall_cycles), .done_count(done_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   // Reference model: in-flight samples as (position, tag), oldest first; position N-1 is the output.
   int               q_pos [$];
   logic [TAG_W-1:0] q_tag [$];
   logic [TAG_W-1:0] m_next_tag;
   longint           m_done;
   longint           m_stall;

   function automatic void model_reset();
      q_pos.delete();
      q_tag.delete();
      m_next_tag = '0;
      m_done     = 0;
      m_stall    = 0;
   endfunction

   function automatic bit m_out_valid();
      return (q_pos.size() > 0) && (q_pos[0] == N - 1);
   endfunction

   // Samples move forward one slot unless blocked by the sample ahead; the input slot is free
   // when the newest sample ends up beyond position 0.
   function automatic bit m_in_ready();
      int lim, s, np;
      if (flush) return 1'b0;
      lim = N - 1;
      s   = (m_out_valid() && out_ready) ? 1 : 0;
      for (int k = s; k < q_pos.size(); k++) begin
         np  = (q_pos[k] + 1 <= lim) ? q_pos[k] + 1 : q_pos[k];
         lim = np - 1;
      end
      return lim >= 0;
   endfunction

   function automatic logic [N-1:0] m_stage_en();
      logic [N-1:0] e;
      int cnt;
      for (int i = 0; i < N; i++) begin
         cnt = 0;
         foreach (q_pos[k]) if (q_pos[k] >= i) cnt++;
         e[i] = out_ready | (cnt < N - i);
      end
      return e;
   endfunction

   function automatic void model_step();
      bit ir;
      int lim, np;
      ir = m_in_ready();
      if (flush) begin
         q_pos.delete();
         q_tag.delete();
         return;
      end
      if (m_out_valid()) begin
         if (out_ready) begin
            m_done++;
            void'(q_pos.pop_front());
            void'(q_tag.pop_front());
         end else begin
            m_stall++;
         end
      end
      lim = N - 1;
      for (int k = 0; k < q_pos.size(); k++) begin
         np       = (q_pos[k] + 1 <= lim) ? q_pos[k] + 1 : q_pos[k];
         q_pos[k] = np;
         lim      = np - 1;
      end
      if (in_valid && ir) begin
         q_pos.push_back(0);
         q_tag.push_back(m_next_tag);
         m_next_tag = m_next_tag + 1'b1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
      total++; if (occupancy !== '0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else passed++;
      total++; if (out_tag !== '0) $display("FAIL reset_out_tag got %0h want 0", out_tag); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
      total++; if (stage_en !== '1) $display("FAIL reset_stage_en got %b want all ones", stage_en); else passed++;
      total++; if (stall_cycles !== '0 || done_count !== '0)
         $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, done_count); else passed++;
      #2;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      int first = -1, seen = 0, peak = 0;
      logic [TAG_W-1:0] t = '1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         in_valid = (cyc == 0); out_ready = 1'b1;
         #1;
         if (cyc == 0) begin
            total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got %0b want 1", in_ready); else passed++;
         end
         if (out_valid === 1'b1) begin
            if (first < 0) first = cyc;
            seen++;
            t = out_tag;
         end
         if (int'(occupancy) > peak) peak = int'(occupancy);
         tick();
      end
      total++; if (first != N) $display("FAIL single_latency got %0d want %0d", first, N); else passed++;
      total++; if (seen != 1) $display("FAIL single_out_cycles got %0d want 1", seen); else passed++;
      total++; if (t !== '0) $display("FAIL single_out_tag got %0h want 0", t); else passed++;
      total++; if (peak != 1) $display("FAIL single_peak_occupancy got %0d want 1", peak); else passed++;
   endtask

   task automatic test_back_to_back();
      longint exp_done;
      apply_reset();
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid = (cyc < 20); out_ready = 1'b1;
         #1;
         if (cyc < 20) begin
            total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc %0d got %0b want 1", cyc, in_ready); else passed++;
         end
         total++;
         if (out_valid !== (cyc >= N && cyc < N + 20))
            $display("FAIL b2b_out_valid cyc %0d got %0b want %0b", cyc, out_valid, (cyc >= N && cyc < N + 20));
         else passed++;
         if (cyc >= N && cyc < N + 20) begin
            total++; if (out_tag !== TAG_W'(cyc - N))
               $display("FAIL b2b_out_tag cyc %0d got %0d want %0d", cyc, out_tag, cyc - N); else passed++;
         end
         tick();
      end
`ifdef POLYLUT_PIPE_PERF_CNT_EN
      exp_done = 20;
`else
      exp_done = 0;
`endif
      total++; if (done_count !== CNT_W'(exp_done)) $display("FAIL b2b_done_count got %0d want %0d", done_count, exp_done); else passed++;
   endtask

   task automatic test_backpressure();
      longint exp_stall;
      int got = 0;
      apply_reset();
      for (int cyc = 0; cyc < N; cyc++) begin
         in_valid = 1'b1; out_ready = 1'b0;
         #1;
         tick();
      end
      for (int cyc = 0; cyc < 10; cyc++) begin
         in_valid = 1'b1; out_ready = 1'b0;
         #1;
         total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %0b want 0", cyc, in_ready); else passed++;
         total++; if (stage_en !== '0) $display("FAIL bp_stage_en cyc %0d got %b want 0", cyc, stage_en); else passed++;
         total++; if (occupancy !== OCC_W'(N)) $display("FAIL bp_occupancy cyc %0d got %0d want %0d", cyc, occupancy, N); else passed++;
         tick();
      end
`ifdef POLYLUT_PIPE_PERF_CNT_EN
      exp_stall = 10;
`else
      exp_stall = 0;
`endif
      total++; if (stall_cycles !== CNT_W'(exp_stall)) $display("FAIL bp_stall_cycles got %0d want %0d", stall_cycles, exp_stall); else passed++;
      for (int cyc = 0; cyc < 12; cyc++) begin
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         if (out_valid === 1'b1) begin
            total++; if (out_tag !== TAG_W'(got)) $display("FAIL bp_resume_tag got %0d want %0d", out_tag, got); else passed++;
            got++;
         end
         tick();
      end
      total++; if (got != N) $display("FAIL bp_drained_count got %0d want %0d", got, N); else passed++;
   endtask

   task automatic test_bubbles();
      int accepted = 0;
      apply_reset();
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = (cyc % 2 == 0); out_ready = 1'b0;
         #1;
         total++;
         if (in_ready !== (accepted < N)) $display("FAIL bubble_in_ready cyc %0d got %0b want %0b", cyc, in_ready, (accepted < N));
         else passed++;
         if (in_valid && in_ready) accepted++;
         tick();
      end
      total++; if (occupancy !== OCC_W'(N)) $display("FAIL bubble_occupancy got %0d want %0d", occupancy, N); else passed++;
   endtask

   task automatic test_flush();
      bit found = 0;
      apply_reset();
      for (int cyc = 0; cyc < 4; cyc++) begin
         in_valid = 1'b1; out_ready = 1'b0;
         #1;
         tick();
      end
      total++; if (occupancy !== OCC_W'(4)) $display("FAIL flush_pre_occupancy got %0d want 4", occupancy); else passed++;
      flush = 1'b1; in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready); else passed++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      total++; if (occupancy !== '0) $display("FAIL flush_occupancy got %0d want 0", occupancy); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %0b want 0", out_valid); else passed++;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 12 && !found; cyc++) begin
         #1;
         if (out_valid === 1'b1) begin
            found = 1;
            total++; if (out_tag !== TAG_W'(4)) $display("FAIL flush_next_tag got %0d want 4", out_tag); else passed++;
         end
         tick();
      end
      if (!found) begin
         total++; $display("FAIL flush_next_tag_timeout got no output want tag 4");
      end
   endtask

   task automatic test_async_reset();
      bit found = 0;
      apply_reset();
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = 1'b1; out_ready = 1'b1;
         #1;
         tick();
      end
      total++; if (out_valid !== 1'b1) $display("FAIL arst_pre_out_valid got %0b want 1", out_valid); else passed++;
      #2;
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got %0b want 0", out_valid); else passed++;
      total++; if (occupancy !== '0) $display("FAIL arst_occupancy got %0d want 0", occupancy); else passed++;
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 12 && !found; cyc++) begin
         #1;
         if (out_valid === 1'b1) begin
            found = 1;
            total++; if (out_tag !== '0) $display("FAIL arst_first_tag got %0d want 0", out_tag); else passed++;
         end
         tick();
      end
      if (!found) begin
         total++; $display("FAIL arst_first_tag_timeout got no output want tag 0");
      end
   endtask

   task automatic test_random();
      longint exp_stall, exp_done;
      apply_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         #1;
         total++; if (in_ready !== m_in_ready()) $display("FAIL rand_in_ready cyc %0d got %0b want %0b", cyc, in_ready, m_in_ready()); else passed++;
         total++; if (out_valid !== m_out_valid()) $display("FAIL rand_out_valid cyc %0d got %0b want %0b", cyc, out_valid, m_out_valid()); else passed++;
         if (m_out_valid()) begin
            total++; if (out_tag !== q_tag[0]) $display("FAIL rand_out_tag cyc %0d got %0d want %0d", cyc, out_tag, q_tag[0]); else passed++;
         end
         total++; if (occupancy !== OCC_W'(q_pos.size())) $display("FAIL rand_occupancy cyc %0d got %0d want %0d", cyc, occupancy, q_pos.size()); else passed++;
         total++; if (stage_en !== m_stage_en()) $display("FAIL rand_stage_en cyc %0d got %b want %b", cyc, stage_en, m_stage_en()); else passed++;
         tick();
      end
      flush = 1'b0;
`ifdef POLYLUT_PIPE_PERF_CNT_EN
      exp_stall = m_stall;
      exp_done  = m_done;
`else
      exp_stall = 0;
      exp_done  = 0;
`endif
      total++; if (stall_cycles !== CNT_W'(exp_stall)) $display("FAIL rand_stall_cycles got %0d want %0d", stall_cycles, exp_stall); else passed++;
      total++; if (done_count !== CNT_W'(exp_done)) $display("FAIL rand_done_count got %0d want %0d", done_count, exp_done); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_bubbles();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/polylut_pipe_ctrl.md
Name: polylut_pipe_ctrl

Overview:
- Valid/ready flow controller for the registered PolyLUT-Add inference pipeline (NUM_STAGES pipeline registers, each followed by layer LUTs and an adder tree).
- Tracks one valid bit and one sequence tag per pipeline register.
- Drives a per-stage load enable into each stage register's enable input.
- Lets the pipeline absorb bubbles and honour downstream backpressure, so the datapath register bank never holds stale or duplicated samples.

Parameters:
- NUM_STAGES, 6, number of pipeline register stages controlled (stage 0 = input register, stage NUM_STAGES-1 = last register, feeding the output layer/adder combinationally).
- TAG_W, 16, width of the per-sample sequence tag.
- CNT_W, 32, width of the performance counters (only with PERF_CNT_EN).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- in_valid  input  1  upstream holds a sample on the datapath input bus.
- in_ready  output  1  stage 0 will load this cycle when in_valid=1.
- out_valid  output  1  final-stage register holds a valid result (datapath output bus valid).
- out_ready  input  1  downstream accepts the result this cycle.
- flush  input  1  synchronous discard of all in-flight samples.
- stage_en  output  NUM_STAGES  bit i = load enable for datapath stage register i.
- out_tag  output  TAG_W  sequence tag of the sample at the output.
- occupancy  output  $clog2(NUM_STAGES+1)  number of valid stages.
- stall_cycles  output  CNT_W  count of cycles with out_valid=1 and out_ready=0 (PERF_CNT_EN only).
- done_count  output  CNT_W  count of output handshakes (PERF_CNT_EN only).

Behaviour:
- Reset (rst=0, async): v[*]=0, tag regs=0, next_tag=0, counters=0. Outputs: out_valid=0, occupancy=0, out_tag=0. in_ready and stage_en follow the combinational rule below (all 1 while reset is held, since v=0 and en cascades from ~v).
- Enable chain (combinational): en[NUM_STAGES]=out_ready; en[i]=~v[i] | en[i+1]; stage_en[i]=en[i]; in_ready=en[0].
- Bubble collapsing: an empty stage always loads, even when downstream is stalled.
- On a clock edge with en[i]=1:
  - stage 0: v[0]<=in_valid, tag[0]<=next_tag.
  - stage i>0: v[i]<=v[i-1], tag[i]<=tag[i-1].
- Stages with en[i]=0 hold both v and tag.
- next_tag increments (wraps at 2^TAG_W) on each accept (in_valid & in_ready). Tags at the output are strictly consecutive mod 2^TAG_W.
- out_valid=v[NUM_STAGES-1]; out_tag=tag[NUM_STAGES-1].
- occupancy = popcount(v), registered view: reflects post-edge state.
- Latency: a sample accepted in cycle 0 with no stalls gives out_valid=1 in cycle NUM_STAGES (6). Throughput is 1 sample/cycle while out_ready=1.
- Backpressure:
  - While out_valid & ~out_ready, the last stage holds.
  - Upstream stages keep loading until every stage is valid; then in_ready=0.
  - No sample is dropped or duplicated.
- Simultaneous out_ready & full pipeline: the whole chain advances; in_ready=1 in the same cycle.
- flush=1 (sync):
  - all v<=0 on the next edge, overriding loads; a sample offered that cycle is not accepted (in_ready forced 0).
  - next_tag is unchanged.
  - no output handshake is counted that cycle.
- Async reset mid-operation: immediate clear as in reset. The datapath register contents are don't-care.

Optional Feature:
- Macro POLYLUT_PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle with out_valid & ~out_ready & ~flush.
  - done_count increments on each out_valid & out_ready & ~flush.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: both ports exist and are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset, then in_valid=1 for 1 cycle with out_ready=1 -> out_valid=1 exactly in cycle 6 for 1 cycle, out_tag=0, occupancy peaks at 1.
- 20 back-to-back inputs with out_ready=1 -> in_ready stays 1, out_valid=1 for cycles 6..25, out_tag sequence 0..19, done_count=20.
- Pipeline full, out_ready=0 for 10 cycles -> in_ready=0, stage_en=0, occupancy=6, stall_cycles=10. Then out_ready=1 -> tags resume consecutively, none lost.
- Alternate in_valid 1/0 with out_ready=0 -> bubbles collapse, occupancy reaches 6 after 6 accepted samples, in_ready drops only then.
- flush asserted with occupancy=4 and in_valid=1 -> next cycle occupancy=0, out_valid=0, next accepted sample carries tag = previous next_tag.
- rst driven low mid-stream between edges -> out_valid and occupancy go 0 immediately; after release the first accept gets tag 0.
